// File: rtl/spi_pkg.sv
// Shared types for the SPI slave core: FSM state encoding and command codes.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        READ_DATA = 3'b001,
        READ_ADD  = 3'b011,
        CHK_CMD   = 3'b111,
        WRITE     = 3'b100
    } spi_state_e;

    // Command field values in rx_data[DATA_W+1:DATA_W]; decoded by the memory side.
    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

endpackage

// File: rtl/spi_miso_ser.sv
// MISO load/shift serialiser: presents a loaded word MSB first, then drives 0.
module spi_miso_ser #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] data,
    output logic              miso,
    output logic              active,
    output logic              done
);

    localparam int REM_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shift_r;
    logic [REM_W-1:0]  rem_r;
    logic              loaded_r;

    // Shifting zeros in behind the word leaves miso at 0 once all bits are out.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift_r  <= '0;
            rem_r    <= '0;
            loaded_r <= 1'b0;
        end else if (load) begin
            shift_r  <= data;
            rem_r    <= REM_W'(DATA_W);
            loaded_r <= 1'b1;
        end else if (rem_r != '0) begin
            shift_r  <= {shift_r[DATA_W-2:0], 1'b0};
            rem_r    <= rem_r - REM_W'(1);
            loaded_r <= loaded_r;
        end else begin
            shift_r  <= shift_r;
            rem_r    <= rem_r;
            loaded_r <= loaded_r;
        end
    end

    assign miso   = shift_r[DATA_W-1];
    assign active = (rem_r != '0);
    assign done   = loaded_r & (rem_r == '0);

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave front end: receives (DATA_W+2)-bit command frames on MOSI and
// serialises one read-data word onto MISO per READ_DATA frame.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ss_n,
    input  logic                mosi,
    output logic                miso,
    output logic [DATA_W+1:0]   rx_data,
    output logic                rx_valid,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                tx_valid,
    output logic                busy,
    output logic                frame_err
);

    localparam int F     = DATA_W + 2;
    localparam int CNT_W = $clog2(DATA_W + 3);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(F);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(F - 1);

    spi_state_e       state_r;
    spi_state_e       state_next;
    logic [CNT_W-1:0] cnt_r;
    logic [F-2:0]     shift_r;
    logic             rd_flag_r;

    logic data_st_s;
    logic sample_s;
    logic complete_s;
    logic abort_s;
    logic load_s;
    logic ser_active_s;
    logic ser_done_s;

    assign data_st_s = (state_r == WRITE) || (state_r == READ_ADD) || (state_r == READ_DATA);

    // Next-state decode and per-cycle datapath strobes; ss_n high always wins.
    always_comb begin
        state_next = state_r;
        sample_s   = 1'b0;
        complete_s = 1'b0;
        abort_s    = 1'b0;
        load_s     = 1'b0;
        if (ss_n) begin
            state_next = IDLE;
            abort_s    = data_st_s && ((cnt_r < CNT_FULL) || ser_active_s);
        end else begin
            sample_s   = (state_r == CHK_CMD) || (data_st_s && (cnt_r < CNT_FULL));
            complete_s = data_st_s && (cnt_r == CNT_LAST);
            load_s     = (state_r == READ_DATA) && (cnt_r == CNT_FULL) && tx_valid
                         && !ser_active_s && !ser_done_s;
            case (state_r)
                IDLE:    state_next = CHK_CMD;
                CHK_CMD: begin
                    if (mosi) begin
                        state_next = rd_flag_r ? READ_DATA : READ_ADD;
                    end else begin
                        state_next = WRITE;
                    end
                end
                WRITE, READ_ADD, READ_DATA: state_next = state_r;
                default: state_next = IDLE;
            endcase
        end
    end

    // State register and busy flag, both tracking the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
        end else begin
            state_r <= state_next;
            busy    <= (state_next != IDLE);
        end
    end

    // Bit counter, receive shifter, frame hand-off, abort pulse and read/write phase flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            shift_r   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rd_flag_r <= 1'b0;
        end else begin
            rx_valid  <= complete_s;
            frame_err <= abort_s;
            if (ss_n) begin
                cnt_r <= '0;
            end else if (sample_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (sample_s) begin
                shift_r <= {shift_r[F-3:0], mosi};
            end else begin
                shift_r <= shift_r;
            end
            if (complete_s) begin
                rx_data <= {shift_r, mosi};
            end else begin
                rx_data <= rx_data;
            end
            if (complete_s && (state_r == READ_ADD)) begin
                rd_flag_r <= 1'b1;
            end else if (complete_s && (state_r == READ_DATA)) begin
                rd_flag_r <= 1'b0;
            end else begin
                rd_flag_r <= rd_flag_r;
            end
        end
    end

    spi_miso_ser #(
        .DATA_W (DATA_W)
    ) u_miso_ser (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .clear  (ss_n),
        .data   (tx_data),
        .miso   (miso),
        .active (ser_active_s),
        .done   (ser_done_s)
    );

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

Parametrised SPI slave front end: deserialises MOSI frames of `DATA_W+2` bits (2-bit command + payload) under `ss_n`, hands each frame to the memory side via `rx_data`/`rx_valid`, and serialises read data from the memory side onto MISO. It is the next generation of the fixed 10-bit slave controller the team verifies with the SPI SVA checker. Compared with that controller it adds a configurable payload width, an explicit frame-abort error and a busy indication. It sits between the SPI pins (already synchronised to `clk`) and the single-port RAM wrapper.

## Interface
- `DATA_W`, 8, payload width in bits; frame length `F = DATA_W+2`; legal range 4..32.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ss_n`  in  1  slave select, active-low, sampled every cycle.
- `mosi`  in  1  serial data in, MSB first.
- `miso`  out  1  serial data out, MSB first.
- `rx_data`  out  DATA_W+2  last complete frame; `[DATA_W+1:DATA_W]` = command.
- `rx_valid`  out  1  one-cycle pulse, `rx_data` valid.
- `tx_data`  in  DATA_W  read data from the memory side.
- `tx_valid`  in  1  `tx_data` valid; honoured only when awaiting read data.
- `busy`  out  1  high whenever state != IDLE.
- `frame_err`  out  1  one-cycle pulse on an aborted frame.

## Operation
- States (package enum): IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- `ss_n=1` in any state: next state IDLE, bit counter cleared, MISO shifter cleared. This has priority over every other transition.
- IDLE: `ss_n=0` -> CHK_CMD.
- CHK_CMD: captures `mosi` as frame bit F-1 (counter = 1), then moves as follows:
  - `mosi=0` -> WRITE.
  - `mosi=1` and `rd_flag=0` -> READ_ADD.
  - `mosi=1` and `rd_flag=1` -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift in one bit per cycle while counter < F.
  - When counter reaches F: update `rx_data`, pulse `rx_valid`.
  - Bits after the frame are ignored; the state holds until `ss_n=1`.
- `rd_flag` (internal, reset 0):
  - Set on frame completion in READ_ADD.
  - Cleared on frame completion in READ_DATA.
  - Not affected by aborts.
- READ_DATA, after `rx_valid`: awaiting read data.
  - First `tx_valid=1` loads `tx_data` into the MISO shifter.
  - `miso` then presents bits DATA_W-1..0, one per cycle.
  - After the last bit, `miso=0` and further `tx_valid` is ignored.
  - `tx_valid` in any other state or phase is ignored.
- Abort: `ss_n` seen high while in WRITE/READ_ADD/READ_DATA with either the counter < F, or a loaded MISO shift not yet finished.
  - Pulse `frame_err` for one cycle.
  - No `rx_valid`; `rx_data` keeps its old value.
- Command bits are passed through unchecked; decoding is the memory side's job.

## Timing
- Reset values: `miso=0`, `rx_data=0`, `rx_valid=0`, `busy=0`, `frame_err=0`, state IDLE, `rd_flag=0`, counter 0.
- Reset in mid-frame behaves identically to power-up. No `frame_err` is raised.
- Edge E0: `ss_n` low in IDLE. Edge E1: MSB sampled in CHK_CMD. Edges E2..EF: remaining F-1 bits sampled.
- `rx_valid` and the new `rx_data` appear in the cycle after EF: latency 1 cycle after the last bit.
- A bit is sampled only when `ss_n=0`. If `ss_n` rises at edge EF, that bit is lost and `frame_err` fires instead of `rx_valid`.
- MISO timing: `tx_valid` sampled at edge T gives `miso=tx_data[DATA_W-1]` from T+1, and bit 0 from T+DATA_W. `miso=0` from T+DATA_W+1.
- `tx_valid` is allowed in the same cycle as `rx_valid` and is accepted there.
- `frame_err` goes high the cycle after the `ss_n` rising sample, together with the IDLE entry.
- Counter width: `$clog2(DATA_W+3)` bits; it saturates at F and never wraps.

## Structure
- Package `spi_pkg` holds:
  - The `spi_state_e` enum with 3-bit encodings IDLE=000, READ_DATA=001, READ_ADD=011, CHK_CMD=111, WRITE=100.
  - Command localparams WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
- Sub-module `spi_miso_ser`: parametrised DATA_W load/shift serialiser with `load`, `clear` and `done` signals. It is instantiated once.
- State register, bit counter, `rd_flag` and the receive shift register live in the top module.

## Test plan
All scenarios use DATA_W=8.
- Reset mid-frame: `rst=1` during bit 5 -> next cycle IDLE, all outputs 0, `rd_flag=0`, no `frame_err`.
- Write frame 10'b00_1010_0101 with `ss_n` low for 11+ cycles -> `rx_valid` for one cycle with `rx_data=10'h0A5` exactly 1 cycle after the 10th bit; state WRITE until `ss_n` rises.
- Read address 10'b10_0011_1100 -> `rx_data=10'h23C`, `rd_flag=1`. Next frame starting with 1 -> READ_DATA.
- Read data: frame 10'b11_0000_0000, then `tx_valid` with `tx_data=8'hC3` -> `miso` = 1,1,0,0,0,0,1,1 on cycles T+1..T+8, 0 after; `rd_flag=0`.
- Abort: `ss_n` rises after 6 bits of a write frame -> one `frame_err` pulse, no `rx_valid`, `rx_data` unchanged, IDLE.
- Stray `tx_valid=1` in WRITE, and again after the MISO shift has completed -> `miso` stays 0, no state change.
